// File: rtl/spm_ctrl.sv
// Sequencer around a serial/parallel multiplier: accepts an operand pair, clears the
// array, streams the multiplicand LSB-first and deserialises the product.
module spm_ctrl #(
    parameter int BITS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BITS-1:0]   in_x,
    input  logic [BITS-1:0]   in_a,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*BITS-1:0] out_p,
    output logic              spm_rst_n,
    output logic              spm_x,
    output logic [BITS-1:0]   spm_a,
    input  logic              spm_y
);

    localparam int CW = $clog2(2*BITS+1);
    localparam logic [CW-1:0] LAST = CW'(2*BITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [CW-1:0]     cnt;
    logic [BITS-1:0]   xs;
    logic [2*BITS-1:0] prod;

    assign in_ready = (state == IDLE) && !rst;

    // Next-state logic for the operation sequence.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    next_state = CLEAR;
                end else begin
                    next_state = IDLE;
                end
            end
            CLEAR: begin
                next_state = RUN;
            end
            RUN: begin
                if (cnt == LAST) begin
                    next_state = DONE;
                end else begin
                    next_state = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    next_state = IDLE;
                end else begin
                    next_state = DONE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Datapath: operand capture, serialisation, product deserialisation.
    // spm_rst_n and spm_x are driven from next_state so both leave a flop cleanly;
    // the array is held cleared whenever no RUN cycle is in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            xs        <= '0;
            prod      <= '0;
            spm_a     <= '0;
            spm_x     <= 1'b0;
            spm_rst_n <= 1'b0;
            out_valid <= 1'b0;
            out_p     <= '0;
        end else begin
            spm_rst_n <= (next_state == RUN);

            if (state == IDLE && in_valid) begin
                xs    <= in_x;
                spm_a <= in_a;
            end else if (next_state == RUN) begin
                xs <= {1'b0, xs[BITS-1:1]};
            end

            if (next_state == RUN) begin
                spm_x <= xs[0];
            end else begin
                spm_x <= 1'b0;
            end

            if (state == RUN) begin
                cnt <= cnt + CW'(1);
            end else begin
                cnt <= '0;
            end

            // spm output lags one cycle, so cnt 0 carries no product bit
            if (state == RUN && cnt != '0) begin
                prod <= {spm_y, prod[2*BITS-1:1]};
            end

            if (state == RUN && cnt == LAST) begin
                out_p     <= {spm_y, prod[2*BITS-1:1]};
                out_valid <= 1'b1;
            end else if (state == DONE && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
